// File: rtl/seg_scan_pkg.sv
// rtl/seg_scan_pkg.sv - shared constants, state encoding and select helpers for seg_scan_driver
package seg_scan_pkg;

    localparam int NUM_DIGITS = 8;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low {g,f,e,d,c,b,a}; entry 15 is the most significant slice.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    function automatic logic is_onehot(input logic [NUM_DIGITS-1:0] v);
        return (v != '0) && ((v & (v - 8'd1)) == '0);
    endfunction

    function automatic logic [2:0] onehot_idx(input logic [NUM_DIGITS-1:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// rtl/hex_to_seg7.sv - combinational 4-bit to active-low seven-segment decoder
module hex_to_seg7
    import seg_scan_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg_n
);

    assign seg_n = HEX_SEG[hex];

endmodule

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - 8-digit multiplexed seven-segment scan driver with blanking dead time
// Optional decimal point support via macro SEG_SCAN_DP_EN.
module seg_scan_driver
    import seg_scan_pkg::*;
#(
    parameter int CLK_DIV   = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        scan_tick,
    input  logic [7:0]  sel_onehot,
    input  logic [31:0] digits,
    input  logic        load,
    output logic [7:0]  an_n,
    output logic [6:0]  seg_n,
    output logic        sel_err
`ifdef SEG_SCAN_DP_EN
    ,
    input  logic [7:0]  dp_mask,
    output logic        dp_n
`endif
);

    localparam int PW = $clog2(CLK_DIV);
    localparam int BW = (BLANK_CYC < 2) ? 1 : $clog2(BLANK_CYC);

    logic [PW-1:0] presc;
    logic [BW-1:0] blank_cnt, blank_cnt_nx;
    scan_state_t   state, state_nx;
    logic [31:0]   shadow, active;
    logic          show_entry;
    logic          sel_ok;
    logic [2:0]    sel_idx;
    logic [3:0]    nibble;
    logic [6:0]    dec_seg;
    logic [7:0]    an_nx;
    logic [6:0]    seg_nx;
    logic          err_nx;

    // scan_tick is registered one count early so it is high while presc == CLK_DIV-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc     <= '0;
            scan_tick <= 1'b0;
        end else begin
            presc     <= (presc == PW'(CLK_DIV - 1)) ? '0 : presc + PW'(1);
            scan_tick <= (presc == PW'(CLK_DIV - 2));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
            active <= '0;
        end else begin
            if (load)      shadow <= digits;
            if (scan_tick) active <= load ? digits : shadow;
        end
    end

    assign sel_ok  = is_onehot(sel_onehot);
    assign sel_idx = onehot_idx(sel_onehot);
    assign nibble  = active[{sel_idx, 2'b00} +: 4];

    hex_to_seg7 u_dec (
        .hex   (nibble),
        .seg_n (dec_seg)
    );

    // Outputs are loaded on the BLANK->SHOW edge and held for the rest of the slot.
    always_comb begin
        state_nx     = state;
        blank_cnt_nx = blank_cnt;
        show_entry   = 1'b0;
        an_nx        = an_n;
        seg_nx       = seg_n;
        err_nx       = sel_err;
        if (scan_tick) begin
            state_nx     = BLANK;
            blank_cnt_nx = '0;
            an_nx        = 8'hFF;
            seg_nx       = SEG_OFF;
        end else if (state == BLANK) begin
            if (blank_cnt == BW'(BLANK_CYC - 1)) begin
                state_nx   = SHOW;
                show_entry = 1'b1;
                if (sel_ok) begin
                    an_nx  = ~sel_onehot;
                    seg_nx = dec_seg;
                end else begin
                    an_nx  = 8'hFF;
                    seg_nx = SEG_OFF;
                    err_nx = 1'b1;
                end
            end else begin
                blank_cnt_nx = blank_cnt + BW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= BLANK;
            blank_cnt <= '0;
            an_n      <= 8'hFF;
            seg_n     <= SEG_OFF;
            sel_err   <= 1'b0;
        end else begin
            state     <= state_nx;
            blank_cnt <= blank_cnt_nx;
            an_n      <= an_nx;
            seg_n     <= seg_nx;
            sel_err   <= err_nx;
        end
    end

`ifdef SEG_SCAN_DP_EN
    logic [7:0] dp_shadow, dp_active;
    logic       dp_nx;

    always_comb begin
        dp_nx = dp_n;
        if (scan_tick)       dp_nx = 1'b1;
        else if (show_entry) dp_nx = sel_ok ? ~dp_active[sel_idx] : 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_shadow <= '0;
            dp_active <= '0;
            dp_n      <= 1'b1;
        end else begin
            if (load)      dp_shadow <= dp_mask;
            if (scan_tick) dp_active <= load ? dp_mask : dp_shadow;
            dp_n <= dp_nx;
        end
    end
`endif

endmodule
